// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Upstream sequencer for a 4:1 mux. It steps the select through channels
//   0..3 and holds each one for a programmable dwell. The mux output is
//   sampled on the last cycle of each dwell, and the four samples are
//   assembled into a frame word. It runs single-shot or continuously, and
//   the scan can be aborted.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        begin a scan (IDLE only)
//   abort        terminate a scan (SCAN only); beats a coincident sample
//   cont         1 = wrap to ch0 after ch3, 0 = stop after one frame
//   dwell        cycles per channel, latched at frame start; 0 acts as 1
//   mux_op       mux output, combinational from sel
//   sel          mux select
//   busy         high while scanning
//   sample_valid 1-cycle pulse per sampled channel
//   sample_ch    channel of the latest sample
//   sample_bit   value of the latest sample
//   frame        last complete frame, bit i = channel i
//   frame_valid  1-cycle pulse when frame updates
module mux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_op,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               sample_valid,
  output logic [1:0]         sample_ch,
  output logic               sample_bit,
  output logic [3:0]         frame,
  output logic               frame_valid
);

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d, dwell_q, dwell_q_d, dwell_eff;
  // ch3 never lands in work: it goes straight from mux_op into frame
  logic [2:0]         work, work_d;
  logic [1:0]         sel_d, sample_ch_d;
  logic               busy_d, sample_valid_d, sample_bit_d, frame_valid_d;
  logic [3:0]         frame_d;
  logic               last;

  assign dwell_eff = (dwell == '0) ? ONE : dwell;
  // dwell_q is never 0 once latched, so dwell_q-1 cannot wrap
  assign last      = (cnt == (dwell_q - ONE));

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    dwell_q_d      = dwell_q;
    work_d         = work;
    sel_d          = sel;
    busy_d         = busy;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch;
    sample_bit_d   = sample_bit;
    frame_d        = frame;
    frame_valid_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          dwell_q_d = dwell_eff;
          sel_d     = 2'd0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sel_d   = 2'd0;
          cnt_d   = '0;
          work_d  = '0;
        end else if (last) begin
          sample_valid_d = 1'b1;
          sample_ch_d    = sel;
          sample_bit_d   = mux_op;
          cnt_d          = '0;
          if (sel != 2'd3) begin
            work_d[sel] = mux_op;
            sel_d       = sel + 2'd1;
          end else begin
            frame_d       = {mux_op, work};
            frame_valid_d = 1'b1;
            sel_d         = 2'd0;
            if (cont) begin
              dwell_q_d = dwell_eff;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dwell_q      <= '0;
      work         <= '0;
      sel          <= 2'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_bit   <= 1'b0;
      frame        <= 4'd0;
      frame_valid  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      dwell_q      <= dwell_q_d;
      work         <= work_d;
      sel          <= sel_d;
      busy         <= busy_d;
      sample_valid <= sample_valid_d;
      sample_ch    <= sample_ch_d;
      sample_bit   <= sample_bit_d;
      frame        <= frame_d;
      frame_valid  <= frame_valid_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl. A behavioural 4:1 mux (mi[sel]) feeds
// mux_op. Outputs are sampled 1 ns after each rising edge. "Edge n" counts
// rising edges after the edge that accepted start.
module tb_mux_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort, cont, mux_op;
  logic [7:0] dwell;
  logic [1:0] sel, sample_ch;
  logic       busy, sample_valid, sample_bit, frame_valid;
  logic [3:0] frame;
  logic [3:0] mi;
  int         errors = 0;
  int         checks = 0;

  assign mux_op = mi[sel];

  mux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .dwell(dwell), .mux_op(mux_op), .sel(sel), .busy(busy),
    .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_bit(sample_bit), .frame(frame), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_sv"}, 32'(sample_valid), 0);
    chk({tag, "_sch"}, 32'(sample_ch), 0);
    chk({tag, "_sbit"}, 32'(sample_bit), 0);
    chk({tag, "_frame"}, 32'(frame), 0);
    chk({tag, "_fv"}, 32'(frame_valid), 0);
  endtask

  initial begin
    logic [3:0] pat;
    int fvc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; dwell = 8'd3; mi = 4'd0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // Single frame, dwell=3. A dwell change and a start pulse arrive mid-scan
    // and must both be ignored.
    pat = 4'b1010; mi = pat; dwell = 8'd3; cont = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("f1_busy0", 32'(busy), 1);
    chk("f1_sel0", 32'(sel), 0);
    for (int n = 1; n <= 12; n++) begin
      if (n == 4) dwell = 8'd7;
      if (n == 5) start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("f1_sel_%0d", n), 32'(sel), 32'((n / 3) % 4));
      chk($sformatf("f1_sv_%0d", n), 32'(sample_valid), 32'(n % 3 == 0));
      if (n % 3 == 0) begin
        chk($sformatf("f1_sch_%0d", n), 32'(sample_ch), 32'(n / 3 - 1));
        chk($sformatf("f1_sbit_%0d", n), 32'(sample_bit), 32'(pat[n / 3 - 1]));
      end
      chk($sformatf("f1_fv_%0d", n), 32'(frame_valid), 32'(n == 12));
      chk($sformatf("f1_busy_%0d", n), 32'(busy), 32'(n < 12));
    end
    chk("f1_frame", 32'(frame), 32'h0A);
    tick();
    chk("f1_idle_busy", 32'(busy), 0);
    chk("f1_idle_fv", 32'(frame_valid), 0);
    chk("f1_idle_sv", 32'(sample_valid), 0);

    // dwell=0 behaves as dwell=1
    mi = 4'b0110; dwell = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("d0_sel_%0d", n), 32'(sel), 32'(n % 4));
      chk($sformatf("d0_sv_%0d", n), 32'(sample_valid), 1);
      chk($sformatf("d0_sch_%0d", n), 32'(sample_ch), 32'(n - 1));
      chk($sformatf("d0_fv_%0d", n), 32'(frame_valid), 32'(n == 4));
    end
    chk("d0_frame", 32'(frame), 32'h6);
    chk("d0_busy", 32'(busy), 0);

    // Continuous, dwell=2. Inputs flip after frame 1; cont is dropped during
    // frame 2.
    mi = 4'b1010; dwell = 8'd2; cont = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 12) cont = 1'b0;
      tick();
      chk($sformatf("ct_sel_%0d", n), 32'(sel), 32'((n / 2) % 4));
      chk($sformatf("ct_sv_%0d", n), 32'(sample_valid), 32'(n % 2 == 0));
      chk($sformatf("ct_fv_%0d", n), 32'(frame_valid), 32'(n == 8 || n == 16));
      chk($sformatf("ct_busy_%0d", n), 32'(busy), 32'(n < 16));
      if (n == 8) begin
        chk("ct_frame1", 32'(frame), 32'hA);
        mi = 4'b0101;
      end
      if (n == 16) chk("ct_frame2", 32'(frame), 32'h5);
    end
    tick();
    chk("ct_stop_busy", 32'(busy), 0);
    chk("ct_stop_sv", 32'(sample_valid), 0);

    // Abort during ch2: frame keeps 0101
    mi = 4'b1111; dwell = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      if (n == 7) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_sel", 32'(sel), 0);
    chk("ab_sv", 32'(sample_valid), 0);
    fvc = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (frame_valid || sample_valid || busy) fvc++;
    end
    chk("ab_quiet", 32'(fvc), 0);
    chk("ab_frame", 32'(frame), 32'h5);

    // Abort exactly on the ch3 sample edge: no pulses at all
    dwell = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n == 4) abort = 1'b1;
      tick();
      if (n < 4) chk($sformatf("abs_sv_%0d", n), 32'(sample_valid), 1);
    end
    abort = 1'b0;
    chk("abs_sv", 32'(sample_valid), 0);
    chk("abs_fv", 32'(frame_valid), 0);
    chk("abs_busy", 32'(busy), 0);
    chk("abs_frame", 32'(frame), 32'h5);

    // Abort in IDLE is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abi_busy", 32'(busy), 0);
    chk("abi_frame", 32'(frame), 32'h5);

    // rst mid-scan, then a clean scan
    mi = 4'b1010; dwell = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zero("rst_mid");
    dwell = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("rs_fv_%0d", n), 32'(frame_valid), 32'(n == 4));
    end
    chk("rs_frame", 32'(frame), 32'hA);

    // dwell=255: frame at edge 1020
    mi = 4'b0011; dwell = 8'd255;
    start = 1'b1; tick(); start = 1'b0;
    fvc = 0;
    for (int n = 1; n <= 1020; n++) begin
      tick();
      if (frame_valid) fvc++;
      if (n == 254) begin
        chk("d255_sel_254", 32'(sel), 0);
        chk("d255_sv_254", 32'(sample_valid), 0);
      end
      if (n == 255) begin
        chk("d255_sel_255", 32'(sel), 1);
        chk("d255_sv_255", 32'(sample_valid), 1);
        chk("d255_sbit_255", 32'(sample_bit), 1);
      end
      if (n == 765) chk("d255_sel_765", 32'(sel), 3);
      if (n == 1019) chk("d255_fv_1019", 32'(frame_valid), 0);
      if (n == 1020) begin
        chk("d255_fv_1020", 32'(frame_valid), 1);
        chk("d255_frame", 32'(frame), 32'h3);
        chk("d255_busy", 32'(busy), 0);
      end
    end
    chk("d255_fv_count", 32'(fvc), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
